// File: rtl/vga_leitor_fb_if.sv
// Frame buffer read port and VGA pin bundle for the scan-out reader.
// master = reader side, slave = frame buffer / pin side.
interface vga_leitor_fb_if;
    logic [18:0] endereco;
    logic [8:0]  dado_fb;
    logic        le_ativo;
    logic [2:0]  vga_r;
    logic [2:0]  vga_g;
    logic [2:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic        fim_quadro;

    modport master (
        output endereco,
        output le_ativo,
        output vga_r,
        output vga_g,
        output vga_b,
        output vga_hs,
        output vga_vs,
        output vga_blank_n,
        output fim_quadro,
        input  dado_fb
    );

    modport slave (
        input  endereco,
        input  le_ativo,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  vga_hs,
        input  vga_vs,
        input  vga_blank_n,
        input  fim_quadro,
        output dado_fb
    );
endinterface

// File: rtl/vga_leitor_fb.sv
// VGA scan-out reader: timing counters, sequential frame buffer addressing
// and a 3-clock pipeline that keeps colour aligned with sync.
module vga_leitor_fb #(
    parameter int H_ATIVO = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_ATIVO = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic            clk,
    input  logic            rst_n,
    vga_leitor_fb_if.master fb
);
    localparam int H_TOTAL = H_ATIVO + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ATIVO + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_ATIVO_W = 10'(H_ATIVO);
    localparam logic [9:0]  V_ATIVO_W = 10'(V_ATIVO);
    localparam logic [9:0]  HS_INI    = 10'(H_ATIVO + H_FP);
    localparam logic [9:0]  HS_FIM    = 10'(H_ATIVO + H_FP + H_SYNC);
    localparam logic [9:0]  VS_INI    = 10'(V_ATIVO + V_FP);
    localparam logic [9:0]  VS_FIM    = 10'(V_ATIVO + V_FP + V_SYNC);
    localparam logic [18:0] ADDR_LAST = 19'(H_ATIVO * V_ATIVO - 1);

    logic [9:0]  h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic [18:0] addr_q, addr_d;
    logic [18:0] endereco_q, endereco_d;
    logic        le_ativo_q, le_ativo_d;
    logic        hs1_q, hs1_d;
    logic        vs1_q, vs1_d;
    logic        act2_q, act2_d;
    logic        hs2_q, hs2_d;
    logic        vs2_q, vs2_d;
    logic [8:0]  rgb_q, rgb_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_n_q, blank_n_d;
    logic        fim_q, fim_d;

    logic act0, hs0, vs0;

    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end

        act0 = (h_q < H_ATIVO_W) && (v_q < V_ATIVO_W);
        hs0  = !((h_q >= HS_INI) && (h_q < HS_FIM));
        vs0  = !((v_q >= VS_INI) && (v_q < VS_FIM));

        // Wrapping on the last pixel keeps the counter inside the frame buffer
        addr_d = addr_q;
        if (((h_q == H_LAST) && (v_q == V_LAST)) || (act0 && (addr_q == ADDR_LAST))) begin
            addr_d = '0;
        end else if (act0) begin
            addr_d = addr_q + 19'd1;
        end

        endereco_d = act0 ? addr_q : endereco_q;
        le_ativo_d = act0;
        hs1_d      = hs0;
        vs1_d      = vs0;

        act2_d = le_ativo_q;
        hs2_d  = hs1_q;
        vs2_d  = vs1_q;

        // Read data is only trusted while the reader owns the port
        rgb_d     = act2_q ? fb.dado_fb : '0;
        blank_n_d = act2_q;
        hs_d      = hs2_q;
        vs_d      = vs2_q;

        fim_d = (h_d == '0) && (v_d == V_ATIVO_W);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q        <= '0;
            v_q        <= '0;
            addr_q     <= '0;
            endereco_q <= '0;
            le_ativo_q <= 1'b0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b1;
            act2_q     <= 1'b0;
            hs2_q      <= 1'b1;
            vs2_q      <= 1'b1;
            rgb_q      <= '0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            blank_n_q  <= 1'b0;
            fim_q      <= 1'b0;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            addr_q     <= addr_d;
            endereco_q <= endereco_d;
            le_ativo_q <= le_ativo_d;
            hs1_q      <= hs1_d;
            vs1_q      <= vs1_d;
            act2_q     <= act2_d;
            hs2_q      <= hs2_d;
            vs2_q      <= vs2_d;
            rgb_q      <= rgb_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            blank_n_q  <= blank_n_d;
            fim_q      <= fim_d;
        end
    end

    assign fb.endereco    = endereco_q;
    assign fb.le_ativo    = le_ativo_q;
    assign fb.vga_r       = rgb_q[8:6];
    assign fb.vga_g       = rgb_q[5:3];
    assign fb.vga_b       = rgb_q[2:0];
    assign fb.vga_hs      = hs_q;
    assign fb.vga_vs      = vs_q;
    assign fb.vga_blank_n = blank_n_q;
    assign fb.fim_quadro  = fim_q;
endmodule

// File: tb/tb_vga_leitor_fb.sv
// Bench for vga_leitor_fb: directed table on the 640x480 instance, and a
// reduced-timing instance checked every clock against a position-based model.
module tb_vga_leitor_fb;
    localparam int SHA = 32, SHF = 4, SHS = 8, SHB = 6;
    localparam int SVA = 12, SVF = 2, SVS = 2, SVB = 3;
    localparam int SHT = SHA + SHF + SHS + SHB;
    localparam int SVT = SVA + SVF + SVS + SVB;
    localparam int SFS = SHT * SVT;

    typedef struct {
        int          cyc;
        logic [18:0] ende;
        logic        le;
        logic        bl;
        logic        hs;
        logic [8:0]  rgb;
    } vec_t;

    logic clk = 1'b0;
    logic rst_f_n = 1'b0;
    logic rst_s_n = 1'b0;
    logic [8:0] key_f = '0;
    logic [8:0] key_s = '0;

    int total = 0;
    int bad = 0;
    int cs = 0;
    logic [18:0] exp_end_s = '0;
    int n_fim = 0;
    int n_vs = 0;

    always #20 clk = ~clk;

    vga_leitor_fb_if bf();
    vga_leitor_fb_if bs();

    vga_leitor_fb u_full (.clk(clk), .rst_n(rst_f_n), .fb(bf));

    vga_leitor_fb #(
        .H_ATIVO(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ATIVO(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
    ) u_small (.clk(clk), .rst_n(rst_s_n), .fb(bs));

    function automatic logic [8:0] fdata(input logic [18:0] a, input logic [8:0] k);
        return a[8:0] ^ k;
    endfunction

    function automatic logic pact(input int p);
        return ((p % SHT) < SHA) && ((p / SHT) < SVA);
    endfunction

    function automatic logic [18:0] paddr(input int p);
        return 19'((p / SHT) * SHA + (p % SHT));
    endfunction

    task automatic chk(input string nm, input int c, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            if (bad <= 40) $display("FAIL %s cycle %0d: got %0h want %0h", nm, c, a, e);
        end
    endtask

    task automatic chk_rst(input string tag, input int c, input logic [18:0] e, input logic le,
                           input logic [8:0] rgb, input logic hs, input logic vs,
                           input logic bl, input logic fim);
        chk({tag, "_rst_end"}, c, 32'(e), 32'd0);
        chk({tag, "_rst_le"}, c, 32'(le), 32'd0);
        chk({tag, "_rst_rgb"}, c, 32'(rgb), 32'd0);
        chk({tag, "_rst_hs"}, c, 32'(hs), 32'd1);
        chk({tag, "_rst_vs"}, c, 32'(vs), 32'd1);
        chk({tag, "_rst_blank"}, c, 32'(bl), 32'd0);
        chk({tag, "_rst_fim"}, c, 32'(fim), 32'd0);
    endtask

    // Frame buffer models: data for an address appears one clock after it is
    // presented; while the reader is idle a writer puts random junk on the bus.
    initial begin : fb_full
        logic [18:0] pa;
        logic pl;
        pa = '0;
        pl = 1'b0;
        bf.dado_fb = 9'h1FF;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_f_n) bf.dado_fb = 9'h1FF;
            else if (pl) bf.dado_fb = fdata(pa, key_f);
            else bf.dado_fb = 9'($urandom);
            pa = bf.endereco;
            pl = bf.le_ativo;
        end
    end

    initial begin : fb_small
        logic [18:0] pa;
        logic pl;
        pa = '0;
        pl = 1'b0;
        bs.dado_fb = 9'h1FF;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_s_n) bs.dado_fb = 9'h1FF;
            else if (pl) bs.dado_fb = fdata(pa, key_s);
            else bs.dado_fb = 9'($urandom);
            pa = bs.endereco;
            pl = bs.le_ativo;
        end
    end

    // One clock of the reduced instance; cs counts edges since reset release,
    // so stage 0 holds frame position cs mod SFS after edge cs.
    task step_s();
        int p;
        int x;
        int y;
        logic a;
        @(posedge clk);
        #2;
        if (!rst_s_n) begin
            cs = 0;
            exp_end_s = '0;
            chk_rst("small", cs, bs.endereco, bs.le_ativo, {bs.vga_r, bs.vga_g, bs.vga_b},
                    bs.vga_hs, bs.vga_vs, bs.vga_blank_n, bs.fim_quadro);
        end else begin
            cs++;
            p = (cs - 1) % SFS;
            if (pact(p)) exp_end_s = paddr(p);
            chk("s_le", cs, 32'(bs.le_ativo), 32'(pact(p)));
            chk("s_end", cs, 32'(bs.endereco), 32'(exp_end_s));
            p = cs % SFS;
            chk("s_fim", cs, 32'(bs.fim_quadro), 32'(p == SVA * SHT));
            if (bs.fim_quadro) n_fim++;
            if (cs >= 3) begin
                p = (cs - 3) % SFS;
                a = pact(p);
                x = p % SHT;
                y = p / SHT;
                chk("s_blank", cs, 32'(bs.vga_blank_n), 32'(a));
                chk("s_rgb", cs, 32'({bs.vga_r, bs.vga_g, bs.vga_b}),
                    32'(a ? fdata(paddr(p), key_s) : 9'd0));
                chk("s_hs", cs, 32'(bs.vga_hs), 32'(!((x >= SHA + SHF) && (x < SHA + SHF + SHS))));
                chk("s_vs", cs, 32'(bs.vga_vs), 32'(!((y >= SVA + SVF) && (y < SVA + SVF + SVS))));
                if (!bs.vga_vs) n_vs++;
            end else begin
                chk("s_early_blank", cs, 32'(bs.vga_blank_n), 32'd0);
                chk("s_early_rgb", cs, 32'({bs.vga_r, bs.vga_g, bs.vga_b}), 32'd0);
                chk("s_early_hs", cs, 32'(bs.vga_hs), 32'd1);
                chk("s_early_vs", cs, 32'(bs.vga_vs), 32'd1);
            end
        end
    endtask

    initial begin : main
        vec_t tv[$];
        int idx;
        int n_bl;
        int n_hs;
        int n_le0;
        int bl_fall;
        int hs_fall;

        key_f = 9'($urandom);
        key_s = 9'($urandom);

        tv.push_back('{1,   19'd0,   1'b1, 1'b0, 1'b1, 9'd0});
        tv.push_back('{3,   19'd2,   1'b1, 1'b1, 1'b1, fdata(19'd0, key_f)});
        tv.push_back('{10,  19'd9,   1'b1, 1'b1, 1'b1, fdata(19'd7, key_f)});
        tv.push_back('{640, 19'd639, 1'b1, 1'b1, 1'b1, fdata(19'd637, key_f)});
        tv.push_back('{641, 19'd639, 1'b0, 1'b1, 1'b1, fdata(19'd638, key_f)});
        tv.push_back('{642, 19'd639, 1'b0, 1'b1, 1'b1, fdata(19'd639, key_f)});
        tv.push_back('{643, 19'd639, 1'b0, 1'b0, 1'b1, 9'd0});
        tv.push_back('{658, 19'd639, 1'b0, 1'b0, 1'b1, 9'd0});
        tv.push_back('{659, 19'd639, 1'b0, 1'b0, 1'b0, 9'd0});
        tv.push_back('{754, 19'd639, 1'b0, 1'b0, 1'b0, 9'd0});
        tv.push_back('{755, 19'd639, 1'b0, 1'b0, 1'b1, 9'd0});
        tv.push_back('{800, 19'd639, 1'b0, 1'b0, 1'b1, 9'd0});
        tv.push_back('{801, 19'd640, 1'b1, 1'b0, 1'b1, 9'd0});
        tv.push_back('{803, 19'd642, 1'b1, 1'b1, 1'b1, fdata(19'd640, key_f)});

        // Full-size instance: reset values, then the first line and a bit
        repeat (5) begin
            @(posedge clk);
            #2;
            chk_rst("full", 0, bf.endereco, bf.le_ativo, {bf.vga_r, bf.vga_g, bf.vga_b},
                    bf.vga_hs, bf.vga_vs, bf.vga_blank_n, bf.fim_quadro);
        end
        rst_f_n = 1'b1;

        idx = 0;
        n_bl = 0;
        n_hs = 0;
        n_le0 = 0;
        bl_fall = -1;
        hs_fall = -1;
        for (int c = 1; c <= 803; c++) begin
            @(posedge clk);
            #2;
            if (c >= 3 && c <= 802) begin
                if (bf.vga_blank_n) n_bl++;
                if (!bf.vga_hs) n_hs++;
                if (!bf.vga_blank_n && bl_fall < 0) bl_fall = c;
                if (!bf.vga_hs && hs_fall < 0) hs_fall = c;
            end
            if (!bf.le_ativo) n_le0++;
            if (idx < tv.size() && tv[idx].cyc == c) begin
                chk("f_end", c, 32'(bf.endereco), 32'(tv[idx].ende));
                chk("f_le", c, 32'(bf.le_ativo), 32'(tv[idx].le));
                chk("f_blank", c, 32'(bf.vga_blank_n), 32'(tv[idx].bl));
                chk("f_hs", c, 32'(bf.vga_hs), 32'(tv[idx].hs));
                chk("f_vs", c, 32'(bf.vga_vs), 32'd1);
                chk("f_rgb", c, 32'({bf.vga_r, bf.vga_g, bf.vga_b}), 32'(tv[idx].rgb));
                idx++;
            end
        end
        chk("f_table_used", 803, 32'(idx), 32'(tv.size()));
        chk("f_blank_cnt", 803, 32'(n_bl), 32'd640);
        chk("f_hs_cnt", 803, 32'(n_hs), 32'd96);
        chk("f_le_low_cnt", 803, 32'(n_le0), 32'd160);
        chk("f_hs_after_blank", 803, 32'(hs_fall - bl_fall), 32'd16);

        // Reduced instance: reset, three full frames with aggregate counts
        repeat (5) step_s();
        rst_s_n = 1'b1;
        n_fim = 0;
        n_vs = 0;
        repeat (3 * SFS + 2) step_s();
        chk("s_fim_per_3frames", cs, 32'(n_fim), 32'd3);
        chk("s_vs_low_3frames", cs, 32'(n_vs), 32'(3 * SVS * SHT));

        // Single-clock reset in mid frame at (h=20, v=7)
        for (int k = 0; k < SFS && (cs % SFS) != (7 * SHT + 20); k++) step_s();
        chk("s_mid_pos", cs, 32'(cs % SFS), 32'(7 * SHT + 20));
        rst_s_n = 1'b0;
        step_s();
        rst_s_n = 1'b1;
        repeat (2 * SHT) step_s();

        // Resets of random length at random points
        repeat (4) begin
            repeat ($urandom_range(1, SFS)) step_s();
            rst_s_n = 1'b0;
            repeat ($urandom_range(1, 3)) step_s();
            rst_s_n = 1'b1;
        end
        repeat (SFS + 10) step_s();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
